// File: rtl/mem_copy_dma.sv
// Byte-block copy engine on the single-port RAM, 2 cycles per byte.
// Define MEM_DMA_FILL_EN to add the pattern-fill mode (FILL state, PatReg).
module mem_copy_dma (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [15:0] Src,
  input  logic [15:0] Dst,
  input  logic [15:0] Len,
  input  logic        Mode,
  input  logic [7:0]  Pattern,
  output logic        Busy,
  output logic        Done,
  output logic        MemWE,
  output logic [15:0] MemAddress,
  output logic [7:0]  MemDataOut,
  input  logic [7:0]  MemDataIn
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
`ifdef MEM_DMA_FILL_EN
    S_FILL,
`endif
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] rem_q, rem_d;

`ifdef MEM_DMA_FILL_EN
  logic [7:0]  pat_q, pat_d;
`else
  logic        unused_cfg;
  assign unused_cfg = ^{Mode, Pattern};
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
`ifdef MEM_DMA_FILL_EN
    pat_d   = pat_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          src_d = Src;
          dst_d = Dst;
          rem_d = Len;
`ifdef MEM_DMA_FILL_EN
          pat_d = Pattern;
          if (Len == 16'h0000)
            state_d = S_DONE;
          else if (Mode)
            state_d = S_FILL;
          else
            state_d = S_RD;
`else
          state_d = (Len == 16'h0000) ? S_DONE : S_RD;
`endif
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        src_d   = src_q + 16'd1;
        dst_d   = dst_q + 16'd1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? S_DONE : S_RD;
      end
`ifdef MEM_DMA_FILL_EN
      S_FILL: begin
        dst_d   = dst_q + 16'd1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? S_DONE : S_FILL;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      rem_q   <= 16'h0000;
`ifdef MEM_DMA_FILL_EN
      pat_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
`ifdef MEM_DMA_FILL_EN
      pat_q   <= pat_d;
`endif
    end
  end

  // RAM controls decode straight from the state flops so reset idles them at once
  always_comb begin
    Busy       = 1'b0;
    Done       = 1'b0;
    MemWE      = 1'b0;
    MemAddress = 16'h0000;
    MemDataOut = 8'h00;
    unique case (state_q)
      S_RD: begin
        Busy       = 1'b1;
        MemAddress = src_q;
      end
      S_WR: begin
        Busy       = 1'b1;
        MemWE      = 1'b1;
        MemAddress = dst_q;
        MemDataOut = MemDataIn;
      end
`ifdef MEM_DMA_FILL_EN
      S_FILL: begin
        Busy       = 1'b1;
        MemWE      = 1'b1;
        MemAddress = dst_q;
        MemDataOut = pat_q;
      end
`endif
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule
